// File: rtl/ms_display_scan_ctrl_if.sv
// rtl/ms_display_scan_ctrl_if.sv - PIO value in, segment/digit pins and status out
interface ms_display_scan_ctrl_if;
    logic [13:0] value_in;
    logic        enable;
    logic [6:0]  seg_n;
    logic [3:0]  dig_n;
    logic [15:0] bcd_out;
    logic        conv_busy;
    logic        overflow;

    modport master (
        output value_in, enable,
        input  seg_n, dig_n, bcd_out, conv_busy, overflow
    );

    modport slave (
        input  value_in, enable,
        output seg_n, dig_n, bcd_out, conv_busy, overflow
    );
endinterface

// File: rtl/ms_display_scan_ctrl.sv
// rtl/ms_display_scan_ctrl.sv - clamp/BCD-convert the ms value and scan a 4-digit 7-seg display
module ms_display_scan_ctrl #(
    parameter int SCAN_DIV      = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ms_display_scan_ctrl_if.slave   bus
);
    typedef enum logic {IDLE, CONVERT} state_t;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0] LAST_ITER = 4'd14;

    state_t      state_q, state_d;
    logic        start_conv;
    logic [13:0] last_value;
    logic [13:0] clamped;
    logic [29:0] shift_q;
    logic [29:0] adjusted;
    logic [29:0] dabble_next;
    logic [3:0]  iter_q;
    logic        ovf_pending;
    logic [15:0] bcd_q;
    logic        overflow_q;

    logic [PW-1:0] presc_q;
    logic [1:0]    index_q;
    logic [3:0]    nibble;
    logic          blank;
    logic [6:0]    seg_d;
    logic [6:0]    seg_q;
    logic [3:0]    dig_q;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // State register for the conversion FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: a changed input starts a conversion; CONVERT ends after the result-write cycle
    always_comb begin
        state_d    = state_q;
        start_conv = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.value_in != last_value) begin
                    start_conv = 1'b1;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                if (iter_q == LAST_ITER) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to nibbles >= 5, then shift the whole register left
    always_comb begin
        clamped  = (bus.value_in > 14'd9999) ? 14'd9999 : bus.value_in;
        adjusted = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (shift_q[14 + 4*i +: 4] >= 4'd5)
                adjusted[14 + 4*i +: 4] = shift_q[14 + 4*i +: 4] + 4'd3;
        end
        dabble_next = {adjusted[28:0], 1'b0};
    end

    // Conversion datapath; bcd_out/overflow only change on the final cycle, never partially
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_value  <= '0;
            shift_q     <= '0;
            iter_q      <= '0;
            ovf_pending <= 1'b0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
        end else if (start_conv) begin
            last_value  <= bus.value_in;
            shift_q     <= {16'd0, clamped};
            ovf_pending <= (bus.value_in > 14'd9999);
            iter_q      <= '0;
        end else if (state_q == CONVERT) begin
            if (iter_q != LAST_ITER) begin
                shift_q <= dabble_next;
                iter_q  <= iter_q + 4'd1;
            end else begin
                bcd_q      <= shift_q[29:14];
                overflow_q <= ovf_pending;
            end
        end
    end

    // Select the nibble for the current digit and decide whether it is a leading zero
    always_comb begin
        nibble = bcd_q[3:0];
        blank  = 1'b0;
        case (index_q)
            2'd0: begin nibble = bcd_q[3:0];   blank = 1'b0;                  end
            2'd1: begin nibble = bcd_q[7:4];   blank = (bcd_q[15:4] == 12'd0); end
            2'd2: begin nibble = bcd_q[11:8];  blank = (bcd_q[15:8] == 8'd0);  end
            2'd3: begin nibble = bcd_q[15:12]; blank = (bcd_q[15:12] == 4'd0); end
            default: ;
        endcase
        seg_d = (BLANK_LEADING && blank) ? 7'h7F : seg_decode(nibble);
    end

    // Refresh prescaler, digit index and registered pin drivers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            index_q <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= 4'hF;
        end else if (!bus.enable) begin
            presc_q <= '0;
            index_q <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= 4'hF;
        end else begin
            dig_q <= ~(4'b0001 << index_q);
            seg_q <= seg_d;
            if (presc_q == PW'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                index_q <= index_q + 2'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign bus.seg_n     = seg_q;
    assign bus.dig_n     = dig_q;
    assign bus.bcd_out   = bcd_q;
    assign bus.overflow  = overflow_q;
    assign bus.conv_busy = (state_q == CONVERT);

endmodule

// File: tb/tb_ms_display_scan_ctrl.sv
// tb/tb_ms_display_scan_ctrl.sv - scoreboard bench for conversion timing, clamping, scan and blanking
module tb_ms_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] value_in = '0;
    logic        enable = 1'b0;

    int checks = 0;
    int passed = 0;
    logic [16:0] sb[$];
    logic [15:0] shown_bcd = '0;

    ms_display_scan_ctrl_if bus_a();
    ms_display_scan_ctrl_if bus_b();

    assign bus_a.value_in = value_in;
    assign bus_a.enable   = enable;
    assign bus_b.value_in = value_in;
    assign bus_b.enable   = enable;

    ms_display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );
    ms_display_scan_ctrl #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        int c;
        c = (v > 9999) ? 9999 : v;
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int k, input bit bl);
        logic [3:0]  n;
        logic [15:0] up;
        n  = b[k*4 +: 4];
        up = b >> (4 * k);
        if (bl && k > 0 && up == 16'd0) return 7'h7F;
        case (n)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    task automatic test_reset();
        logic ok;
        enable = 1'b1;
        repeat (3) step();
        reset_n = 1'b1;
        repeat (3) step();
        value_in = 14'd1234;
        repeat (4) step();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (bus_a.bcd_out !== 16'h0000) $display("FAIL reset_bcd got %h want 0000", bus_a.bcd_out); else passed++;
        checks++; if (bus_a.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus_a.overflow); else passed++;
        checks++; if (bus_a.conv_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus_a.conv_busy); else passed++;
        checks++; if (bus_a.seg_n !== 7'h7F) $display("FAIL reset_seg got %h want 7f", bus_a.seg_n); else passed++;
        checks++; if (bus_a.dig_n !== 4'hF) $display("FAIL reset_dig got %h want f", bus_a.dig_n); else passed++;
        value_in = 14'd0;
        step();
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_a.conv_busy !== 1'b0 || bus_a.bcd_out !== 16'h0000) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL reset_no_partial got busy=%b bcd=%h want 0/0000", bus_a.conv_busy, bus_a.bcd_out); else passed++;
        shown_bcd = 16'h0000;
    endtask

    task automatic run_conversion(input int v);
        logic [16:0] exp;
        logic        hold_ok;
        int          cnt;
        sb.push_back({(v > 9999), to_bcd(v)});
        value_in = 14'(v);
        step();
        checks++; if (bus_a.conv_busy !== 1'b1) $display("FAIL conv_start_busy v=%0d got %b want 1", v, bus_a.conv_busy); else passed++;
        cnt = 0;
        hold_ok = 1'b1;
        while (bus_a.conv_busy === 1'b1 && cnt < 40) begin
            if (bus_a.bcd_out !== shown_bcd) hold_ok = 1'b0;
            step();
            cnt++;
        end
        checks++; if (cnt != 15) $display("FAIL conv_latency v=%0d got %0d want 15", v, cnt); else passed++;
        checks++; if (hold_ok !== 1'b1) $display("FAIL conv_no_early_result v=%0d got 0 want 1", v); else passed++;
        checks++;
        if (sb.size() == 0) $display("FAIL conv_scoreboard v=%0d got empty want entry", v);
        else begin
            exp = sb.pop_front();
            if ({bus_a.overflow, bus_a.bcd_out} !== exp)
                $display("FAIL conv_result v=%0d got ovf=%b bcd=%h want ovf=%b bcd=%h", v, bus_a.overflow, bus_a.bcd_out, exp[16], exp[15:0]);
            else passed++;
            shown_bcd = exp[15:0];
        end
    endtask

    task automatic test_no_change();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus_a.conv_busy !== 1'b0 || bus_a.bcd_out !== shown_bcd) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) $display("FAIL no_change got busy=%b bcd=%h want 0/%h", bus_a.conv_busy, bus_a.bcd_out, shown_bcd); else passed++;
    endtask

    task automatic test_change_during_conversion();
        logic [16:0] exp;
        sb.push_back({1'b0, to_bcd(500)});
        value_in = 14'd500;
        step();
        repeat (5) step();
        sb.push_back({1'b0, to_bcd(777)});
        value_in = 14'd777;
        repeat (10) step();
        checks++; if (bus_a.conv_busy !== 1'b0) $display("FAIL chg_first_done got busy=%b want 0", bus_a.conv_busy); else passed++;
        exp = sb.pop_front();
        checks++; if (bus_a.bcd_out !== exp[15:0]) $display("FAIL chg_first_result got %h want %h", bus_a.bcd_out, exp[15:0]); else passed++;
        step();
        checks++; if (bus_a.conv_busy !== 1'b1) $display("FAIL chg_second_start got busy=%b want 1", bus_a.conv_busy); else passed++;
        repeat (14) step();
        checks++; if (bus_a.bcd_out !== exp[15:0]) $display("FAIL chg_second_early got %h want %h", bus_a.bcd_out, exp[15:0]); else passed++;
        step();
        exp = sb.pop_front();
        checks++; if (bus_a.conv_busy !== 1'b0) $display("FAIL chg_second_done got busy=%b want 0", bus_a.conv_busy); else passed++;
        checks++; if (bus_a.bcd_out !== exp[15:0]) $display("FAIL chg_second_result got %h want %h", bus_a.bcd_out, exp[15:0]); else passed++;
        shown_bcd = exp[15:0];
    endtask

    task automatic test_scan(input int v);
        logic [15:0] b;
        logic [3:0]  ed;
        int          k;
        run_conversion(v);
        b = to_bcd(v);
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int c = 0; c < 32; c++) begin
            step();
            k  = (c / 4) % 4;
            ed = ~(4'b0001 << k);
            checks++; if (bus_a.dig_n !== ed) $display("FAIL scan_dig_a v=%0d c=%0d got %h want %h", v, c, bus_a.dig_n, ed); else passed++;
            checks++; if (bus_b.dig_n !== ed) $display("FAIL scan_dig_b v=%0d c=%0d got %h want %h", v, c, bus_b.dig_n, ed); else passed++;
            checks++; if (bus_a.seg_n !== exp_seg(b, k, 1'b1)) $display("FAIL scan_seg_blank v=%0d c=%0d got %h want %h", v, c, bus_a.seg_n, exp_seg(b, k, 1'b1)); else passed++;
            checks++; if (bus_b.seg_n !== exp_seg(b, k, 1'b0)) $display("FAIL scan_seg_noblank v=%0d c=%0d got %h want %h", v, c, bus_b.seg_n, exp_seg(b, k, 1'b0)); else passed++;
        end
    endtask

    task automatic test_enable_off();
        repeat (6) step();
        enable = 1'b0;
        step();
        checks++; if (bus_a.dig_n !== 4'hF) $display("FAIL en_off_dig got %h want f", bus_a.dig_n); else passed++;
        checks++; if (bus_a.seg_n !== 7'h7F) $display("FAIL en_off_seg got %h want 7f", bus_a.seg_n); else passed++;
        repeat (3) step();
        checks++; if (bus_a.dig_n !== 4'hF) $display("FAIL en_off_hold got %h want f", bus_a.dig_n); else passed++;
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (bus_a.dig_n !== ((c < 4) ? 4'hE : 4'hD)) $display("FAIL en_restart c=%0d got %h want %h", c, bus_a.dig_n, (c < 4) ? 4'hE : 4'hD);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        run_conversion(1234);
        run_conversion(12000);
        run_conversion(9999);
        run_conversion(0);
        test_no_change();
        test_change_during_conversion();
        test_scan(7);
        test_scan(50);
        test_enable_off();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
